// File: rtl/pdp8_iot_pkg.sv
// Shared definitions for the PDP-8/I IOT pulse generator: sequencer states,
// MB bit positions (PDP-8 numbering, bit 0 = MSB) and MB field helpers.
package pdp8_iot_pkg;

    localparam int unsigned MB_W      = 12;
    localparam int unsigned MB_IOP1   = 11;
    localparam int unsigned MB_IOP2   = 10;
    localparam int unsigned MB_IOP4   = 9;
    localparam int unsigned MB_DEV_HI = 3;
    localparam int unsigned MB_DEV_LO = 8;
    localparam int unsigned DEV_W     = MB_DEV_LO - MB_DEV_HI + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SLOT1,
        GAP1,
        SLOT2,
        GAP2,
        SLOT4,
        TAIL
    } iot_state_t;

    // PDP-8 bit n lives at vector index MB_W-1-n
    function automatic logic mb_bit(input logic [MB_W-1:0] mb, input int unsigned idx);
        return mb[4'(MB_W - 1 - idx)];
    endfunction

    function automatic logic [DEV_W-1:0] dev_code(input logic [MB_W-1:0] mb);
        logic [DEV_W-1:0] d;
        d = '0;
        for (int unsigned i = 0; i < DEV_W; i++) begin
            d[3'(DEV_W - 1 - i)] = mb_bit(mb, MB_DEV_HI + i);
        end
        return d;
    endfunction

endpackage

// File: rtl/iot_slot_timer.sv
// Loadable down-counter timing each sequencer state; tc_c flags the last cycle.
module iot_slot_timer
#(
    parameter int unsigned CNT_W = 3
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             tc_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tc_c = (count == '0);

endmodule

// File: rtl/iot_pulse_gen.sv
// IOT pulse generator: latches the device code and plays IOP1/IOP2/IOP4 slots
// as active-low registered drive enables. Option macro: IOT_SKIP_SAMPLE_EN.
module iot_pulse_gen
    import pdp8_iot_pkg::*;
#(
    parameter int unsigned SETUP_W = 2,
    parameter int unsigned PULSE_W = 4,
    parameter int unsigned GAP_W   = 2
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] mb,
    input  logic        skip_bus_n,
    output logic [5:0]  dev_sel,
    output logic        iop1_n,
    output logic        iop2_n,
    output logic        iop4_n,
    output logic        busy,
    output logic        done,
    output logic        skip
);

    localparam int unsigned MAX_W = (SETUP_W > PULSE_W)
                                  ? ((SETUP_W > GAP_W) ? SETUP_W : GAP_W)
                                  : ((PULSE_W > GAP_W) ? PULSE_W : GAP_W);
    localparam int unsigned CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_W - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);

    iot_state_t       state;
    iot_state_t       next_state;
    logic [2:0]       en;
    logic             accept_c;
    logic             end_c;
    logic             tc_c;
    logic             load_c;
    logic [CNT_W-1:0] load_val_c;

    iot_slot_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_c),
        .value (load_val_c),
        .tc_c  (tc_c)
    );

    // the done cycle still blocks start so a request is never half-accepted
    assign accept_c = (state == IDLE) && start && !done;
    assign end_c    = (state == TAIL) && tc_c;

    always_comb begin
        next_state = state;
        load_c     = 1'b0;
        load_val_c = '0;
        case (state)
            IDLE:  if (accept_c) begin next_state = SETUP; load_c = 1'b1; load_val_c = SETUP_LD; end
            SETUP: if (tc_c) begin next_state = SLOT1; load_c = 1'b1; load_val_c = PULSE_LD; end
            SLOT1: if (tc_c) begin next_state = GAP1;  load_c = 1'b1; load_val_c = GAP_LD;   end
            GAP1:  if (tc_c) begin next_state = SLOT2; load_c = 1'b1; load_val_c = PULSE_LD; end
            SLOT2: if (tc_c) begin next_state = GAP2;  load_c = 1'b1; load_val_c = GAP_LD;   end
            GAP2:  if (tc_c) begin next_state = SLOT4; load_c = 1'b1; load_val_c = PULSE_LD; end
            SLOT4: if (tc_c) begin next_state = TAIL;  load_c = 1'b1; load_val_c = GAP_LD;   end
            TAIL:  if (tc_c) begin next_state = IDLE; end
            default: next_state = IDLE;
        endcase
    end

    // outputs are decoded from next_state so they line up with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            en      <= '0;
            dev_sel <= '0;
            iop1_n  <= 1'b1;
            iop2_n  <= 1'b1;
            iop4_n  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state  <= next_state;
            busy   <= (next_state != IDLE);
            done   <= end_c;
            iop1_n <= !((next_state == SLOT1) && en[0]);
            iop2_n <= !((next_state == SLOT2) && en[1]);
            iop4_n <= !((next_state == SLOT4) && en[2]);
            if (accept_c) begin
                dev_sel <= dev_code(mb);
                en      <= {mb_bit(mb, MB_IOP4), mb_bit(mb, MB_IOP2), mb_bit(mb, MB_IOP1)};
            end
        end
    end

`ifdef IOT_SKIP_SAMPLE_EN
    logic [1:0] skip_sync;
    logic       skip_flag;
    logic       sample_c;

    assign sample_c = tc_c && (((state == SLOT1) && en[0]) ||
                               ((state == SLOT2) && en[1]) ||
                               ((state == SLOT4) && en[2]));

    // SKIP is asynchronous to the sequencer; sample the synchronised level at slot end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_sync <= 2'b11;
            skip_flag <= 1'b0;
            skip      <= 1'b0;
        end else begin
            skip_sync <= {skip_sync[0], skip_bus_n};
            if (accept_c) begin
                skip_flag <= 1'b0;
            end else if (sample_c && !skip_sync[1]) begin
                skip_flag <= 1'b1;
            end
            skip <= end_c && skip_flag;
        end
    end
`else
    logic unused_skip_bus;
    assign unused_skip_bus = skip_bus_n;
    assign skip = 1'b0;
`endif

endmodule
